dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 66 ++++++
 rtl/dmem_if.sv | 35 +++
 rtl/dmem_rr_arb.sv | 33 +++
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller slice.
//   - state_t       : controller FSM states (IDLE, READ, WRITE, RESP)
//   - F3_*          : load/store size codes carried on req_funct3
//   - DEPTH_DEFAULT : default data-memory size in 32-bit words
//   - load_extract  : pick and extend a byte/half/word out of a memory word
//   - store_merge   : replace the addressed byte/half lane(s) of a memory word
//   - access_err    : illegal size code, misalignment, or out-of-range address
package dmem_pkg;

  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Only called for legal B/H stores, so funct3 is either a byte or half code.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [31:0] w;
    w = word;
    if (funct3 == F3_B) w[{off, 3'b000} +: 8]   = wdata[7:0];
    else                w[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return w;
  endfunction

  function automatic logic access_err(input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic e;
    case (funct3)
      F3_B, F3_BU: e = 1'b0;
      F3_H, F3_HU: e = addr[0];
      F3_W:        e = |addr[1:0];
      default:     e = 1'b1;
    endcase
    return e || (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Two-port request / shared response bus between requesters and dmem_ctrl.
// Port 0 is the core LSU, port 1 is debug/DMA.
//   req_valid/req_ready [1:0] : per-port handshake
//   req_we, req_addr, req_wdata, req_funct3 : per-port payload
//   rsp_valid [1:0]           : one-cycle completion pulse to the owning port
//   rsp_rdata, rsp_err        : shared response data, qualified by rsp_valid
//
// Handshake: a request transfers on a cycle where req_valid[p] and
// req_ready[p] are both 1. A requester raises valid with a stable payload and
// holds both unchanged until that cycle; ready never depends on anything but
// valid and controller state. Responses carry no back-pressure.
interface dmem_if;
  import dmem_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][2:0]  req_funct3;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-port round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-port request
//   accept     : a grant was taken this cycle; rotates priority
//   grant      : one-hot grant (all zero when nothing requests)
//   grant_idx  : index of the granted port
// When both ports request, the port that was not granted last wins. After
// reset port 0 holds priority.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic prio_q;  // port that wins a tie

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) grant_idx = prio_q;
    else if (req[1])  grant_idx = 1'b1;
    grant = 2'b00;
    if (req != 2'b00) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)       prio_q <= 1'b0;
    else if (accept) prio_q <= ~grant_idx;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates two requesters onto a single word-wide
// data memory with combinational read data, one transaction at a time.
// Sub-word stores are done as read-modify-write.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_if.slave request/response bus
//   mem_we, mem_addr, mem_wdata : memory write strobe, word address, data
//   mem_rdata  : combinational memory read data for mem_addr
//   dbg_state  : current FSM state
// Timing from accept cycle N: loads, word stores and errors respond at N+2
// (word-store write at N+1); sub-word stores write at N+2, respond at N+3.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output state_t      dbg_state
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  state_t      state_q, state_d;
  logic        lat_we;
  logic        lat_port;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;
  logic [31:0] word_q;    // memory word captured for read-modify-write
  logic [31:0] result_q;  // response data, already zero for stores/errors
  logic        err_q;

  logic [1:0]  grant;
  logic        grant_idx;
  logic        any_valid;
  logic        accept;
  logic        err_now;
  logic        word_store;

  assign any_valid  = |bus.req_valid;
  assign accept     = (state_q == IDLE) && any_valid && !reset;
  assign err_now    = access_err(lat_f3, lat_addr, MEM_BYTES);
  assign word_store = lat_we && (lat_f3 == F3_W) && !err_now;
  assign dbg_state  = state_q;

  dmem_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.rsp_rdata = 32'h0;
    bus.rsp_err   = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          bus.req_ready = grant;
          state_d       = READ;
        end
      end
      READ: begin
        mem_addr = {lat_addr[31:2], 2'b00};
        if (word_store) begin
          mem_we    = 1'b1;
          mem_wdata = lat_wdata;
        end
        // Only a legal sub-word store needs the extra merge cycle.
        if (lat_we && !err_now && (lat_f3 != F3_W)) state_d = WRITE;
        else                                         state_d = RESP;
      end
      WRITE: begin
        mem_addr  = {lat_addr[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = store_merge(word_q, lat_wdata, lat_f3, lat_addr[1:0]);
        state_d   = RESP;
      end
      RESP: begin
        bus.rsp_valid[lat_port] = 1'b1;
        bus.rsp_rdata           = result_q;
        bus.rsp_err             = err_q;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over every state, so a write in flight never reaches memory.
    if (reset) begin
      state_d       = IDLE;
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      bus.rsp_rdata = 32'h0;
      bus.rsp_err   = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = 32'h0;
      mem_wdata     = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_f3    <= 3'b000;
      word_q    <= 32'h0;
      result_q  <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            lat_we    <= bus.req_we[grant_idx];
            lat_addr  <= bus.req_addr[grant_idx];
            lat_wdata <= bus.req_wdata[grant_idx];
            lat_f3    <= bus.req_funct3[grant_idx];
            lat_port  <= grant_idx;
          end
        end
        READ: begin
          err_q    <= err_now;
          word_q   <= mem_rdata;
          result_q <= (err_now || lat_we) ? 32'h0
                                          : load_extract(mem_rdata, lat_f3, lat_addr[1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  dmem_if bus ();

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Memory attached to the DUT, and the reference image the bench predicts.
  logic [31:0] phys_mem [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem  [DEPTH] = '{default: 32'h0};

  assign mem_rdata = (mem_addr < MEM_BYTES) ? phys_mem[mem_addr[AW+1:2]] : 32'h0;
  always @(posedge clk)
    if (mem_we && (mem_addr < MEM_BYTES)) phys_mem[mem_addr[AW+1:2]] <= mem_wdata;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cyc;
  } wr_t;

  rsp_t exp_q [$];
  wr_t  we_q  [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_err(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] size;
    case (f3)
      3'b000, 3'b100: size = 32'd1;
      3'b001, 3'b101: size = 32'd2;
      3'b010:         size = 32'd4;
      default:        return 1'b1;
    endcase
    if (a >= MEM_BYTES) return 1'b1;
    return (a % size) != 32'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    if (f3 == 3'b010) return d;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  // Queue the response (and memory write, if any) a request accepted in
  // cycle acc must produce. Table vectors supply their own rdata/err.
  task automatic push_expect(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3, input int acc,
                             input logic use_tbl, input logic [31:0] t_rdata, input logic t_err);
    logic        e;
    logic [31:0] rd, nw;
    int          lat;
    rsp_t        r;
    wr_t         w;
    e   = model_err(f3, addr);
    rd  = (e || we) ? 32'h0 : model_load(ref_mem[addr[AW+1:2]], f3, addr[1:0]);
    lat = (we && !e && f3 != 3'b010) ? 3 : 2;
    r.port  = port;
    r.err   = use_tbl ? t_err : e;
    r.rdata = use_tbl ? t_rdata : rd;
    r.cyc   = 16'(acc + lat);
    exp_q.push_back(r);
    if (we && !e) begin
      nw     = model_store(ref_mem[addr[AW+1:2]], wdata, f3, addr[1:0]);
      w.addr = {addr[31:2], 2'b00};
      w.data = nw;
      w.cyc  = 16'(acc + lat - 1);
      we_q.push_back(w);
      ref_mem[addr[AW+1:2]] = nw;
    end
  endtask

  // Monitor: every response and every memory write must be one the bench queued.
  rsp_t mon_r;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (bus.rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
      else begin
        mon_r = exp_q.pop_front();
        check("rsp_port",  32'(bus.rsp_valid), mon_r.port ? 32'h2 : 32'h1);
        check("rsp_rdata", bus.rsp_rdata, mon_r.rdata);
        check("rsp_err",   32'(bus.rsp_err), 32'(mon_r.err));
        check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (mem_we) begin
      if (we_q.size() == 0) check("unexpected_mem_we", {mem_addr[31:1], mem_we}, 32'h0);
      else begin
        mon_w = we_q.pop_front();
        check("we_addr",  mem_addr, mon_w.addr);
        check("we_data",  mem_wdata, mon_w.data);
        check("we_cycle", 32'(cyc), 32'(mon_w.cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    bus.req_valid[port]  = 1'b1;
    bus.req_we[port]     = we;
    bus.req_addr[port]   = addr;
    bus.req_wdata[port]  = wdata;
    bus.req_funct3[port] = f3;
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic use_tbl, input logic [31:0] t_rdata, input logic t_err);
    bit got;
    int acc;
    got = 0;
    acc = 0;
    @(posedge clk); #1;
    set_req(port, we, addr, wdata, f3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check("accept_timeout", 32'h0, 32'h1);
      bus.req_valid = 2'b00;
      return;
    end
    check("grant", 32'(bus.req_ready), port ? 32'h2 : 32'h1);
    acc = cyc;
    push_expect(port, we, addr, wdata, f3, acc, use_tbl, t_rdata, t_err);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("read_addr", mem_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("rsp_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  logic [2:0] f3_set [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int n;
    logic [2:0]  f3;
    logic [31:0] a;

    //            port we  addr      wdata         f3      exp_rdata     err
    tbl[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W,  32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h11, 32'h00000080, F3_B,  32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h11, 32'h0,        F3_B,  32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h11, 32'h0,        F3_BU, 32'h00000080, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD80EF, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h12, 32'h00008001, F3_H,  32'h00000000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFF8001, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h12, 32'h0,        F3_HU, 32'h00008001, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFF80, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h10, 32'h0,        F3_BU, 32'h000000EF, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h10, 32'h0,        F3_B,  32'hFFFFFFEF, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h10, 32'h0,        F3_H,  32'hFFFF80EF, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h12, 32'h0,        F3_W,  32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h13, 32'h0,        F3_H,  32'h00000000, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'b011, 32'h00000000, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 32'h80, 32'h0,        F3_W,  32'h00000000, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 32'h80, 32'hDEADBEEF, F3_W,  32'h00000000, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 32'h11, 32'h00001234, F3_H,  32'h00000000, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 32'h11, 32'h0,        F3_HU, 32'h00000000, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'b110, 32'h00000000, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b111, 32'h00000000, 1'b1};
    tbl[22] = '{1'b0, 1'b1, 32'h7C, 32'h12345678, F3_W,  32'h00000000, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 32'h7F, 32'h000000AB, F3_B,  32'h00000000, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 32'h7E, 32'h0,        F3_H,  32'hFFFFAB34, 1'b0};
    tbl[25] = '{1'b1, 1'b0, 32'h7E, 32'h0,        F3_HU, 32'h0000AB34, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 32'h7C, 32'h0,        F3_W,  32'hAB345678, 1'b0};
    tbl[27] = '{1'b0, 1'b1, 32'h20, 32'h11223344, F3_W,  32'h00000000, 1'b0};
    tbl[28] = '{1'b1, 1'b0, 32'h7C, 32'h0,        F3_BU, 32'h00000078, 1'b0};
    tbl[29] = '{1'b0, 1'b1, 32'h81, 32'h00000055, F3_B,  32'h00000000, 1'b1};

    // Reset with both ports requesting: everything must stay quiet.
    bus.req_valid  = 2'b11;
    bus.req_we     = 2'b11;
    bus.req_addr   = {32'h14, 32'h10};
    bus.req_wdata  = {32'h5555AAAA, 32'hCAFEF00D};
    bus.req_funct3 = {F3_W, F3_W};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",     32'(bus.req_ready), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_err",   32'(bus.rsp_err), 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_mem_we",    32'(mem_we), 32'h0);
    check("reset_mem_addr",  mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_state",     32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 2'b00;

    // Table-driven vectors.
    for (int v = 0; v < NV; v++)
      run_txn(tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].f3,
              1'b1, tbl[v].exp_rdata, tbl[v].exp_err);

    // Reset during the WRITE cycle of an SH from port 0 (pointer now favours 1).
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'h22, 32'h0000AAAA, F3_H);
    @(negedge clk);
    check("sh_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    check("sh_in_write", 32'(dbg_state), 32'(WRITE));
    reset = 1'b1;
    @(negedge clk);
    check("rst_write_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    check("rst_word_kept", phys_mem[8], 32'h11223344);

    // Both ports valid continuously: grants must alternate starting at port 0.
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h20, 32'h0, F3_W);
    set_req(1'b1, 1'b0, 32'h7C, 32'h0, F3_W);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        check("dual_grant", 32'(bus.req_ready), (n % 2 == 1) ? 32'h2 : 32'h1);
        push_expect(bus.req_ready[1], 1'b0, bus.req_ready[1] ? 32'h7C : 32'h20, 32'h0,
                    F3_W, cyc, 1'b0, 32'h0, 1'b0);
        n++;
      end
      if (n < 4) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    check("dual_count", 32'(n), 32'd4);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("dual_drain", 32'(exp_q.size()), 32'h0);

    // Random traffic against the reference image.
    for (int i = 0; i < 40; i++) begin
      f3 = f3_set[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 9) < 8) begin
        if (f3 == 3'b010) a[1:0] = 2'b00;
        else if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
      end
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, f3,
              1'b0, 32'h0, 1'b0);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check("mem_image", phys_mem[i], ref_mem[i]);
    check("rsp_left", 32'(exp_q.size()), 32'h0);
    check("we_left",  32'(we_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
